i2s_tx_serializer: RTL

I2S transmitter stage that drives the serial bus monitored by our I2S VIP (`i2s_intf`). It accepts stereo sample pairs from the system side over a valid/ready handshake, buffers one pair, and serializes them MSB-first onto SD with generated SCK and WS in Philips I2S format (WS leads data by one SCK). All logic runs on the system clock; SCK is a divided, registered output.

---
 rtl/i2s_tx_serializer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/i2s_tx_serializer.sv
// I2S (Philips format) transmitter: buffers one stereo pair behind a valid/ready
// handshake and shifts it out MSB-first with locally generated SCK and WS.
module i2s_tx_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    output logic                  sck,
    output logic                  ws,
    output logic                  sd,
    output logic                  underrun,
    output logic                  busy
);
    localparam int FW  = 2 * SLOT_WIDTH;
    localparam int BW  = $clog2(FW);
    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PAD = SLOT_WIDTH - DATA_WIDTH;

    localparam logic [BW-1:0]  B_LAST = BW'(FW - 1);
    localparam logic [BW-1:0]  WS_LO  = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0]  WS_HI  = BW'(FW - 2);
    localparam logic [DCW-1:0] D_LAST = DCW'(CLK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                state_q;
    logic                  hold_full_q;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_r_q;
    logic [FW-1:0]         shift_q;
    logic [BW-1:0]         b_q;
    logic [DCW-1:0]        d_q;
    logic                  sck_q, ws_q, sd_q, underrun_q;

    logic [SLOT_WIDTH-1:0] slot_l_d, slot_r_d;
    logic [FW-1:0]         frame_d;
    logic [BW-1:0]         b_inc;
    logic                  tick, fall_evt, wrap, load_go, accept;

    // Handshake: a pair transfers on any clk edge where s_valid && s_ready;
    // s_ready is the registered inverse of hold_full, so it cannot react to
    // a frame load until the cycle after that load.
    always_comb begin
        slot_l_d = SLOT_WIDTH'(hold_l_q) << PAD;
        slot_r_d = SLOT_WIDTH'(hold_r_q) << PAD;
        frame_d  = hold_full_q ? {slot_l_d, slot_r_d} : '0;
        b_inc    = b_q + 1'b1;
        tick     = (d_q == D_LAST);
        fall_evt = (state_q == RUN) && tick && sck_q;
        wrap     = fall_evt && (b_q == B_LAST);
        load_go  = enable && ((state_q == IDLE) || wrap);
        accept   = s_valid && !hold_full_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            shift_q     <= '0;
            b_q         <= '0;
            d_q         <= '0;
            sck_q       <= 1'b0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (load_go) begin
                shift_q     <= frame_d;
                sd_q        <= frame_d[FW-1];
                ws_q        <= 1'b0;
                b_q         <= '0;
                underrun_q  <= !hold_full_q;
                hold_full_q <= 1'b0;
            end
            // Placed after the load so a pair accepted on an empty-hold load edge survives.
            if (accept) begin
                hold_full_q <= 1'b1;
                hold_l_q    <= s_left;
                hold_r_q    <= s_right;
            end
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RUN;
                        d_q     <= '0;
                        sck_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        d_q   <= '0;
                        sck_q <= !sck_q;
                    end else begin
                        d_q <= d_q + 1'b1;
                    end
                    if (wrap && !enable) begin
                        state_q <= IDLE;
                        sd_q    <= 1'b0;
                        ws_q    <= 1'b0;
                        b_q     <= '0;
                    end else if (fall_evt && !wrap) begin
                        b_q     <= b_inc;
                        shift_q <= shift_q << 1;
                        sd_q    <= shift_q[FW-2];
                        ws_q    <= (b_inc >= WS_LO) && (b_inc <= WS_HI);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready  = !hold_full_q;
    assign sck      = sck_q;
    assign ws       = ws_q;
    assign sd       = sd_q;
    assign underrun = underrun_q;
    assign busy     = (state_q == RUN);
endmodule
